// File: rtl/ysyx_22040365_ifu.sv
// ysyx_22040365_ifu -- instruction fetch unit.
//
// Owns the PC and fetches one instruction at a time from instruction memory.
// The fetched word is held for decode with its PC until decode takes it.
// Execute can redirect the PC at any time outside IDLE/HALT. A fetch that is
// already in flight when a redirect arrives is flagged with `drop`, so its
// response is thrown away instead of being shown to decode.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   imem_req_valid/ready     fetch request handshake, imem_addr = current pc
//   imem_rsp_valid/data      one response per accepted request
//   inst_valid/ready         decode handshake, inst/inst_pc held while valid
//   redirect_valid/pc        branch/jump target from execute
//   fetch_misalign           sticky misaligned-redirect flag
//
// Optional feature: YSYX_22040365_IFU_MISALIGN_EN
//   defined   - a redirect to a target that is not 4-byte aligned sets
//               fetch_misalign and parks the unit in HALT until reset.
//   undefined - redirect_pc[1:0] is forced to zero, there is no HALT state and
//               fetch_misalign is tied 0.
module ysyx_22040365_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_misalign
);

`ifdef YSYX_22040365_IFU_MISALIGN_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t      state;
    logic [63:0] pc;
    logic        drop;
    logic [63:0] redirect_tgt;

`ifdef YSYX_22040365_IFU_MISALIGN_EN
    logic redirect_mis;
    logic misalign_q;

    assign redirect_tgt   = redirect_pc;
    assign redirect_mis   = |redirect_pc[1:0];
    assign fetch_misalign = misalign_q;
`else
    // Low target bits are discarded: every PC is word aligned.
    logic redirect_lsb_unused;

    assign redirect_tgt        = {redirect_pc[63:2], 2'b00};
    assign redirect_lsb_unused = |redirect_pc[1:0];
    assign fetch_misalign      = 1'b0;
`endif

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
`ifdef YSYX_22040365_IFU_MISALIGN_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (imem_req_ready) begin
                        // A request accepted in the redirect cycle still
                        // carries the old pc, so its response is stale.
                        if (redirect_valid) drop <= 1'b1;
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_tgt;
                        if (imem_rsp_valid) begin
                            drop           <= 1'b0;
                            state          <= S_REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop) begin
                            drop           <= 1'b0;
                            state          <= S_REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A redirect wins over a same-cycle consume: no pc+4.
                    if (redirect_valid || inst_ready) begin
                        pc             <= redirect_valid ? redirect_tgt : pc + 64'd4;
                        inst_valid     <= 1'b0;
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
`ifdef YSYX_22040365_IFU_MISALIGN_EN
                S_HALT: begin
                end
`endif
                default: state <= S_IDLE;
            endcase

`ifdef YSYX_22040365_IFU_MISALIGN_EN
            // Misaligned redirect overrides the normal transition chosen above.
            if (redirect_valid && redirect_mis &&
                (state == S_REQ || state == S_WAIT || state == S_HOLD)) begin
                state          <= S_HALT;
                misalign_q     <= 1'b1;
                imem_req_valid <= 1'b0;
                inst_valid     <= 1'b0;
                drop           <= (state == S_REQ && imem_req_ready) ||
                                  (state == S_WAIT && !imem_rsp_valid);
            end
`endif
        end
    end

endmodule
